// File: rtl/core_pkg.sv
// core_pkg: shared core constants for register addressing and data width
package core_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS = 16;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;
endpackage

// File: rtl/core_regfile.sv
// core_regfile: 16x16 register file, two registered read ports, one write port, r0 hardwired to zero
module core_regfile #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  import core_pkg::*;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] mem [DEPTH];
  logic we;
  // only a definite 1 enables a write, so an unknown enable cannot corrupt the array
  assign we = (wen === 1'b1) && (waddr != ZERO);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= (raddr0 == ZERO) ? '0 : mem[raddr0];
      rdata1 <= (raddr1 == ZERO) ? '0 : mem[raddr1];
      if (we) mem[waddr] <= wdata;
    end
  end
endmodule

// File: tb/tb_core_regfile.sv
// tb_core_regfile: randomized and directed scoreboard bench for core_regfile
module tb_core_regfile;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] raddr0 = 0, raddr1 = 0, waddr = 0;
  logic [15:0] rdata0, rdata1, wdata = 0;
  logic wen = 0;
  int tests = 0, fails = 0;
  logic [15:0] model [16];
  logic [15:0] q0 [$], q1 [$];
  logic [3:0] qa0 [$], qa1 [$];

  core_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .rdata0(rdata0),
    .raddr1(raddr1), .rdata1(rdata1),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every edge with an outstanding read gets compared
  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      logic [3:0] a0, a1;
      logic [15:0] e0, e1;
      a0 = qa0.pop_front(); a1 = qa1.pop_front();
      e0 = q0.pop_front(); e1 = q1.pop_front();
      check($sformatf("rdata0 r%0d", a0), rdata0, e0);
      check($sformatf("rdata1 r%0d", a1), rdata1, e1);
    end
  end

  task automatic op(input logic [3:0] a0, input logic [3:0] a1, input logic w,
                    input logic [3:0] wa, input logic [15:0] wd);
    @(negedge clk);
    raddr0 = a0; raddr1 = a1; wen = w; waddr = wa; wdata = wd;
    qa0.push_back(a0); qa1.push_back(a1);
    q0.push_back(a0 == 0 ? 16'h0 : model[a0]);
    q1.push_back(a1 == 0 ? 16'h0 : model[a1]);
    if (wen === 1'b1 && wa != 0) model[wa] = wd;
  endtask

  task automatic drain();
    int budget = 10;
    while (q0.size() != 0 && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d reads outstanding, expected 0", q0.size());
    end
    @(negedge clk);
    wen = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 0;
    #3;
    check("reset rdata0", rdata0, 16'h0);
    check("reset rdata1", rdata1, 16'h0);
    @(negedge clk); rst_n = 1;
    op(5, 5, 1, 5, 16'h1234);
    op(5, 5, 0, 0, 16'h0);
    op(5, 5, 0, 0, 16'h0);
    op(0, 0, 1, 0, 16'hBEEF);
    op(0, 0, 0, 0, 16'h0);
    op(0, 0, 1, 7, 16'h0001);
    op(7, 7, 1, 7, 16'h00FF);
    op(7, 0, 0, 0, 16'h0);
    op(0, 0, 1, 3, 16'h5555);
    op(3, 3, 0, 3, 16'hAAAA);
    op(3, 3, 1'bx, 3, 16'hAAAA);
    op(3, 3, 0, 0, 16'h0);
    for (int i = 1; i < 16; i++) op(0, 0, 1, 4'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 16; i++) op(4'(i), 4'(16 - i), 0, 0, 16'h0);
    op(9, 12, 0, 0, 16'h0);
    drain();
    #2;
    // async reset must clear outputs without a clock edge
    rst_n = 0;
    #1;
    check("async rdata0", rdata0, 16'h0);
    check("async rdata1", rdata1, 16'h0);
    for (int i = 0; i < 16; i++) model[i] = 0;
    raddr0 = 5; raddr1 = 9; wen = 1; waddr = 5; wdata = 16'hFFFF;
    @(posedge clk); #1;
    check("inreset rdata0", rdata0, 16'h0);
    check("inreset rdata1", rdata1, 16'h0);
    @(negedge clk); wen = 0; rst_n = 1;
    for (int i = 0; i < 16; i++) op(4'(i), 4'(15 - i), 0, 0, 16'h0);
    for (int n = 0; n < 400; n++) begin
      logic w;
      int r;
      r = $urandom_range(0, 9);
      w = (r < 5) ? 1'b1 : (r == 9) ? 1'bx : 1'b0;
      op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w,
         4'($urandom_range(0, 15)), 16'($urandom));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
